// File: rtl/stream_arbiter.sv
// Round-robin AXI-Stream arbiter: the selected slave keeps the master until its tlast
// beat is accepted. Data passes through combinationally and is never stored.
module stream_arbiter #(
   parameter int S_DATA_COUNT = 2,
   parameter int T_DATA_WIDTH = 8,
   localparam int T_ID_M_WIDTH = $clog2(S_DATA_COUNT)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [S_DATA_COUNT-1:0]              s_tvalid_i,
   input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_tdata_i,
   input  logic [S_DATA_COUNT-1:0]              s_tlast_i,
   output logic [S_DATA_COUNT-1:0]              s_tready_o,
   output logic                                 m_tvalid_o,
   output logic [T_DATA_WIDTH-1:0]              m_tdata_o,
   output logic                                 m_tlast_o,
   output logic [T_ID_M_WIDTH-1:0]              m_tid_o,
   input  logic                                 m_tready_i
);

   generate
      if (S_DATA_COUNT < 2 || S_DATA_COUNT > 16) begin : g_cfg_err
         $error("stream_arbiter: S_DATA_COUNT must be in 2..16");
      end
   endgenerate

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state, state_n;
   logic [T_ID_M_WIDTH-1:0] grant, grant_n;
   logic [T_ID_M_WIDTH-1:0] rr_ptr, rr_ptr_n;
   logic [T_DATA_WIDTH-1:0] tdata_arr [S_DATA_COUNT];
   logic                    found;
   int unsigned             sum;
   logic [T_ID_M_WIDTH-1:0] idx;

   always_comb begin
      for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
         tdata_arr[k] = s_tdata_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n    = state;
      grant_n    = grant;
      rr_ptr_n   = rr_ptr;
      found      = 1'b0;
      sum        = 0;
      idx        = '0;
      s_tready_o = '0;
      m_tvalid_o = 1'b0;
      m_tdata_o  = '0;
      m_tlast_o  = 1'b0;
      m_tid_o    = grant;
      case (state)
         IDLE: begin
            // Rotated search starting at rr_ptr; wrap by subtraction so non-power-of-2 counts work.
            for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
               sum = 32'(rr_ptr) + i;
               if (sum >= S_DATA_COUNT) sum = sum - S_DATA_COUNT;
               idx = T_ID_M_WIDTH'(sum);
               if (!found && s_tvalid_i[idx]) begin
                  found   = 1'b1;
                  grant_n = idx;
                  state_n = LOCKED;
               end
            end
         end
         LOCKED: begin
            m_tvalid_o        = s_tvalid_i[grant];
            m_tdata_o         = tdata_arr[grant];
            m_tlast_o         = s_tlast_i[grant];
            s_tready_o[grant] = m_tready_i;
            if (s_tvalid_i[grant] && m_tready_i && s_tlast_i[grant]) begin
               state_n = IDLE;
               if (grant == T_ID_M_WIDTH'(S_DATA_COUNT - 1)) rr_ptr_n = '0;
               else rr_ptr_n = grant + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: 4-slave and 3-slave instances checked every cycle
// against an owner/pointer model, plus hand-computed expectations per scenario.
module tb_stream_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  v4 = '0, l4 = '0, st4;
   logic [31:0] d4 = '0;
   logic        r4 = 1'b0, mv4, ml4;
   logic [7:0]  md4;
   logic [1:0]  mid4;
   logic [2:0]  v3 = '0, l3 = '0, st3;
   logic [23:0] d3 = '0;
   logic        r3 = 1'b0, mv3, ml3;
   logic [7:0]  md3;
   logic [1:0]  mid3;

   int tests = 0;
   int fails = 0;
   // model state per instance: owner (-1 = none), round-robin pointer, last grant
   int own [2] = '{-1, -1};
   int ptr [2] = '{0, 0};
   int gnt [2] = '{0, 0};

   always #5 clk = ~clk;

   stream_arbiter #(.S_DATA_COUNT(4), .T_DATA_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst), .s_tvalid_i(v4), .s_tdata_i(d4), .s_tlast_i(l4),
      .s_tready_o(st4), .m_tvalid_o(mv4), .m_tdata_o(md4), .m_tlast_o(ml4),
      .m_tid_o(mid4), .m_tready_i(r4));

   stream_arbiter #(.S_DATA_COUNT(3), .T_DATA_WIDTH(8)) dut3 (
      .clk_i(clk), .rst_i(rst), .s_tvalid_i(v3), .s_tdata_i(d3), .s_tlast_i(l3),
      .s_tready_o(st3), .m_tvalid_o(mv3), .m_tdata_o(md3), .m_tlast_o(ml3),
      .m_tid_o(mid3), .m_tready_i(r3));

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void mstep(input int n, input logic [15:0] v, input logic [15:0] l,
                                 input logic rdy, inout int o, inout int p, inout int g);
      if (o < 0) begin
         for (int i = 0; i < n; i++) begin
            int k;
            k = (p + i) % n;
            if (v[k]) begin
               o = k;
               g = k;
               break;
            end
         end
      end else if (v[o] && rdy && l[o]) begin
         p = (o + 1) % n;
         o = -1;
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         own = '{-1, -1};
         ptr = '{0, 0};
         gnt = '{0, 0};
      end else begin
         mstep(4, 16'(v4), 16'(l4), r4, own[0], ptr[0], gnt[0]);
         mstep(3, 16'(v3), 16'(l3), r3, own[1], ptr[1], gnt[1]);
      end
   end

   task automatic cmp(input string tag, input int o, input int g, input logic [15:0] v,
                      input logic [15:0] l, input logic [127:0] d, input logic r,
                      input logic [15:0] st, input logic mv, input logic [7:0] md,
                      input logic ml, input logic [1:0] mid);
      logic       ev, el;
      logic [7:0] ed;
      logic [15:0] es;
      ev = 1'b0; el = 1'b0; ed = '0; es = '0;
      if (!rst && o >= 0) begin
         ev    = v[o];
         el    = l[o];
         ed    = d[o*8 +: 8];
         es[o] = r;
      end
      chk({tag, "_tvalid"}, int'(mv), int'(ev));
      chk({tag, "_tlast"}, int'(ml), int'(el));
      chk({tag, "_tdata"}, int'(md), int'(ed));
      chk({tag, "_tready"}, int'(st), int'(es));
      chk({tag, "_tid"}, int'(mid), g);
   endtask

   always @(negedge clk) begin
      cmp("m4", own[0], gnt[0], 16'(v4), 16'(l4), 128'(d4), r4, 16'(st4), mv4, md4, ml4, mid4);
      cmp("m3", own[1], gnt[1], 16'(v3), 16'(l3), 128'(d3), r3, 16'(st3), mv3, md3, ml3, mid3);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int gq[$];
   int idles;
   int exp2 [5] = '{0, 1, 2, 3, 0};

   initial begin
      repeat (2) tick;
      rst = 1'b0;

      // single beat from slave 2
      v4 = 4'b0100; l4 = 4'b0100; d4[23:16] = 8'hA5; r4 = 1'b1;
      @(negedge clk);
      chk("s1_c0_tvalid", int'(mv4), 0);
      chk("s1_c0_tready", int'(st4), 0);
      chk("s1_c0_tdata", int'(md4), 0);
      tick;
      @(negedge clk);
      chk("s1_c1_tvalid", int'(mv4), 1);
      chk("s1_c1_tdata", int'(md4), 8'hA5);
      chk("s1_c1_tid", int'(mid4), 2);
      chk("s1_c1_tready", int'(st4), 4'b0100);
      tick;
      v4 = '0; l4 = '0;
      @(negedge clk);
      chk("s1_c2_tvalid", int'(mv4), 0);
      chk("s1_c2_tid_hold", int'(mid4), 2);
      chk("s1_c2_model_ptr", ptr[0], 3);

      // all slaves requesting with 1-beat packets
      tick; rst = 1'b1; tick; rst = 1'b0;
      v4 = 4'hF; l4 = 4'hF; d4 = {8'h04, 8'h03, 8'h02, 8'h01}; r4 = 1'b1;
      idles = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (mv4 && r4) gq.push_back(int'(mid4));
         else idles++;
         tick;
      end
      v4 = '0; l4 = '0;
      chk("s2_grant_count", gq.size(), 5);
      chk("s2_idle_count", idles, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < gq.size()) chk($sformatf("s2_grant%0d", i), gq[i], exp2[i]);
      end

      // slave 1 three-beat packet, slave 0 requests mid-packet
      v4 = 4'b0010; d4[15:8] = 8'h11;
      @(negedge clk);
      chk("s3_idle_tvalid", int'(mv4), 0);
      tick;
      @(negedge clk);
      chk("s3_b1_tid", int'(mid4), 1);
      chk("s3_b1_tdata", int'(md4), 8'h11);
      tick;
      d4[15:8] = 8'h12; d4[7:0] = 8'h50; v4 = 4'b0011;
      @(negedge clk);
      chk("s3_b2_tid", int'(mid4), 1);
      chk("s3_b2_tready0", int'(st4[0]), 0);
      tick;
      d4[15:8] = 8'h13; l4 = 4'b0010;
      @(negedge clk);
      chk("s3_b3_tid", int'(mid4), 1);
      chk("s3_b3_tdata", int'(md4), 8'h13);
      chk("s3_b3_tready0", int'(st4[0]), 0);
      tick;
      v4 = 4'b0001; l4 = 4'b0001;
      @(negedge clk);
      chk("s3_gap_tvalid", int'(mv4), 0);
      tick;
      @(negedge clk);
      chk("s3_next_tid", int'(mid4), 0);
      chk("s3_next_tdata", int'(md4), 8'h50);
      tick;
      v4 = '0; l4 = '0;

      // slave 3 two-beat packet with master stall
      v4 = 4'b1000; d4[31:24] = 8'h31; r4 = 1'b1;
      @(negedge clk);
      chk("s4_idle_tvalid", int'(mv4), 0);
      tick;
      @(negedge clk);
      chk("s4_b1_tdata", int'(md4), 8'h31);
      chk("s4_b1_tid", int'(mid4), 3);
      tick;
      d4[31:24] = 8'h32; l4 = 4'b1000; r4 = 1'b0;
      @(negedge clk);
      chk("s4_stall_tvalid", int'(mv4), 1);
      chk("s4_stall_tready", int'(st4), 0);
      tick;
      r4 = 1'b1;
      @(negedge clk);
      chk("s4_b2_tdata", int'(md4), 8'h32);
      chk("s4_b2_tready", int'(st4), 4'b1000);
      chk("s4_b2_tlast", int'(ml4), 1);
      tick;
      v4 = '0; l4 = '0;
      @(negedge clk);
      chk("s4_done_tvalid", int'(mv4), 0);
      chk("s4_model_ptr", ptr[0], 0);

      // reset during beat 2 of a slave 1 packet
      v4 = 4'b0010; d4[15:8] = 8'h41;
      tick;
      @(negedge clk);
      chk("s5_b1_tid", int'(mid4), 1);
      chk("s5_b1_tdata", int'(md4), 8'h41);
      tick;
      d4[15:8] = 8'h42; rst = 1'b1;
      @(negedge clk);
      chk("s5_rst_tvalid", int'(mv4), 0);
      chk("s5_rst_tready", int'(st4), 0);
      tick;
      rst = 1'b0; v4 = 4'b1010; l4 = 4'b1010; d4[31:24] = 8'h43; d4[15:8] = 8'h44;
      @(negedge clk);
      chk("s5_idle_tvalid", int'(mv4), 0);
      tick;
      @(negedge clk);
      chk("s5_regrant_tid", int'(mid4), 1);
      chk("s5_regrant_tdata", int'(md4), 8'h44);
      tick;
      v4 = '0; l4 = '0;

      // 3-slave wrap: slave 2 finishes, then slaves 0 and 2 compete
      v3 = 3'b100; l3 = 3'b100; d3[23:16] = 8'h77; r3 = 1'b1;
      @(negedge clk);
      chk("s6_idle_tvalid", int'(mv3), 0);
      tick;
      @(negedge clk);
      chk("s6_b_tid", int'(mid3), 2);
      chk("s6_b_tdata", int'(md3), 8'h77);
      tick;
      v3 = 3'b101; l3 = 3'b101; d3[7:0] = 8'h70;
      @(negedge clk);
      chk("s6_gap_tvalid", int'(mv3), 0);
      chk("s6_model_ptr", ptr[1], 0);
      tick;
      @(negedge clk);
      chk("s6_next_tid", int'(mid3), 0);
      chk("s6_next_tdata", int'(md3), 8'h70);
      tick;
      v3 = '0; l3 = '0;

      repeat (2) tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
